profile_reader: RTL

- Read-side sequencer for the per-user height/weight profile store: 32 users, 12-bit height and 12-bit weight, combinational read.
- On a start command it walks a user index range and drives the store's user index.
- Each programmed entry is registered and streamed out as a record over a valid/ready handshake.
- The `busy` output tells the top level to route the store's index from this block and to hold off writes.

---
 rtl/calcore_pkg.sv | 22 ++
 rtl/profile_reader.sv | 108 ++++++++++
 2 files changed

// File: rtl/calcore_pkg.sv
// Shared types and sizing for the profile store and its read sequencer.
package calcore_pkg;

    localparam int unsigned NUM_USERS  = 32;
    localparam int unsigned USER_IDX_W = 5;
    localparam int unsigned METRIC_W   = 12;

    // One profile record as streamed to consumers.
    typedef struct packed {
        logic [USER_IDX_W-1:0] index;
        logic [METRIC_W-1:0]   height;
        logic [METRIC_W-1:0]   weight;
    } user_rec_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDone
    } reader_state_e;

endpackage

// File: rtl/profile_reader.sv
// Read-side sequencer for the height/weight profile store: walks a user index
// range, registers each entry and streams it out over a valid/ready handshake.
module profile_reader
    import calcore_pkg::*;
#(
    parameter int unsigned NUM_USERS  = calcore_pkg::NUM_USERS,
    parameter int unsigned IDX_W      = calcore_pkg::USER_IDX_W,
    parameter int unsigned METRIC_W   = calcore_pkg::METRIC_W,
    parameter bit          SKIP_EMPTY = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IDX_W-1:0]    first_idx,
    input  logic [IDX_W-1:0]    last_idx,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    mem_index,
    input  logic [METRIC_W-1:0] mem_height,
    input  logic [METRIC_W-1:0] mem_weight,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [IDX_W-1:0]    rec_index,
    output logic [METRIC_W-1:0] rec_height,
    output logic [METRIC_W-1:0] rec_weight,
    output logic [IDX_W:0]      rec_count
);

    // Highest valid user slot; the scan stops here even if last_idx says otherwise.
    localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(NUM_USERS - 1);

    reader_state_e    state_q;
    logic [IDX_W-1:0] cur_q;
    logic [IDX_W-1:0] last_q;
    user_rec_t        rec_q;
    logic [IDX_W:0]   rec_count_q;

    logic at_end;
    logic entry_empty;

    assign at_end      = (cur_q == last_q) || (cur_q == MaxIdx);
    assign entry_empty = SKIP_EMPTY && (mem_height == '0) && (mem_weight == '0);

    // Outputs decode directly from the state flop and datapath registers.
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign rec_valid  = (state_q == StHold);
    assign mem_index  = (state_q == StIdle) ? '0 : cur_q;
    assign rec_index  = rec_q.index;
    assign rec_height = rec_q.height;
    assign rec_weight = rec_q.weight;
    assign rec_count  = rec_count_q;

    // Scan FSM and record datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            last_q      <= '0;
            rec_q       <= '0;
            rec_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cur_q       <= first_idx;
                        last_q      <= last_idx;
                        rec_count_q <= '0;
                        state_q     <= (first_idx <= last_idx) ? StFetch : StDone;
                    end
                end
                StFetch: begin
                    rec_q.index  <= cur_q;
                    rec_q.height <= mem_height;
                    rec_q.weight <= mem_weight;
                    if (entry_empty) begin
                        // Empty slot: nothing to emit, move straight on.
                        if (at_end) begin
                            state_q <= StDone;
                        end else begin
                            cur_q <= cur_q + 1'b1;
                        end
                    end else begin
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (rec_ready) begin
                        rec_count_q <= rec_count_q + 1'b1;
                        if (at_end) begin
                            state_q <= StDone;
                        end else begin
                            cur_q   <= cur_q + 1'b1;
                            state_q <= StFetch;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
